// File: rtl/aes_iter_ctrl.sv
// Iterative AES encryption sequencer: round-0 AddRoundKey here, rounds 1..RND_NUM via roundComb.
// Optional abort input is compiled in when AES_CTRL_ABORT_EN is defined.
module aes_iter_ctrl #(
    parameter int unsigned KEY_SIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef AES_CTRL_ABORT_EN
    input  logic                abort_i,
`endif
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        in_state_i,
    input  logic [KEY_SIZE-1:0] in_key_i,
    output logic [127:0]        rc_state_o,
    output logic [KEY_SIZE-1:0] rc_key_o,
    output logic [3:0]          rc_num_o,
    input  logic [127:0]        rc_state_out_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        out_state_o,
    output logic                busy_o
);

    localparam int unsigned RND_NUM = (KEY_SIZE == 256) ? 14 : (KEY_SIZE == 192) ? 12 : 10;
    localparam logic [3:0]  RndLast = 4'(RND_NUM);

    if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
        $error("aes_iter_ctrl: KEY_SIZE must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              st_q, st_d;
    logic [127:0]        state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [3:0]          num_q, num_d;
    logic                in_ready_q, out_valid_q, busy_q;
    logic                abort_w;

`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        key_d   = key_q;
        num_d   = num_q;
        unique case (st_q)
            StIdle: begin
                if (in_valid_i) begin
                    state_d = in_state_i ^ in_key_i[KEY_SIZE-1 -: 128];
                    key_d   = in_key_i;
                    num_d   = 4'd1;
                    st_d    = StRun;
                end
            end
            StRun: begin
                state_d = rc_state_out_i;
                if (num_q == RndLast) begin
                    st_d = StDone;
                end else begin
                    num_d = num_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    st_d  = StIdle;
                    num_d = 4'd0;
                end
            end
            default: st_d = StIdle;
        endcase
        // Abort wins over a same-cycle out_ready; in IDLE it has no effect.
        if (abort_w && st_q != StIdle) begin
            st_d  = StIdle;
            num_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q        <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            num_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            key_q       <= key_d;
            num_q       <= num_d;
            in_ready_q  <= (st_d == StIdle);
            out_valid_q <= (st_d == StDone);
            busy_q      <= (st_d != StIdle);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign rc_state_o  = state_q;
    assign rc_key_o    = key_q;
    assign rc_num_o    = num_q;
    assign out_state_o = state_q;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: three key sizes, each paired with a behavioural AES round function.
module tb_aes_iter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   in_valid, out_ready;
    logic [127:0] in_state;
    logic [255:0] key_in;
`ifdef AES_CTRL_ABORT_EN
    logic         abort;
`endif
    wire  [2:0]   in_ready, out_valid, busy;
    wire  [127:0] rc_st [3];
    wire  [127:0] os [3];
    wire  [3:0]   rc_num [3];
    wire  [127:0] rc_key0;
    wire  [191:0] rc_key1;
    wire  [255:0] rc_key2;
    logic [127:0] rc_out0, rc_out1, rc_out2;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural AES (FIPS-197) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv, base;
        inv = 8'h01; base = b;
        for (int k = 1; k < 8; k++) begin  // b^254 = prod of b^(2^k), k=1..7
            base = gmul(base, base);
            inv  = gmul(inv, base);
        end
        if (b == 8'h00) inv = 8'h00;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int ks, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        nk = ks / 32;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[(nk-1-i)*32 +: 32];
        for (int i = nk; i < 4*r+4; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input bit last);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int ks);
        logic [127:0] s;
        int nr;
        nr = ks / 32 + 6;
        s  = pt ^ round_key(key, ks, 0);
        for (int r = 1; r <= nr; r++) s = aes_round(s, round_key(key, ks, r), r == nr);
        return s;
    endfunction

    // Stand-in for roundComb: num==0 output is a don't-care.
    function automatic logic [127:0] rc_model(input logic [127:0] st, input logic [255:0] key,
                                              input int ks, input logic [3:0] num);
        if (num == 4'd0) return st;
        return aes_round(st, round_key(key, ks, int'(num)), int'(num) == ks / 32 + 6);
    endfunction

    always_comb rc_out0 = rc_model(rc_st[0], {128'h0, rc_key0}, 128, rc_num[0]);
    always_comb rc_out1 = rc_model(rc_st[1], {64'h0, rc_key1}, 192, rc_num[1]);
    always_comb rc_out2 = rc_model(rc_st[2], rc_key2, 256, rc_num[2]);

    // ---------------- DUTs ----------------
    aes_iter_ctrl #(.KEY_SIZE(128)) u_aes128 (
        .clk_i(clk), .rst_i(rst),
`ifdef AES_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_state_i(in_state),
        .in_key_i(key_in[127:0]), .rc_state_o(rc_st[0]), .rc_key_o(rc_key0),
        .rc_num_o(rc_num[0]), .rc_state_out_i(rc_out0), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .out_state_o(os[0]), .busy_o(busy[0]));

    aes_iter_ctrl #(.KEY_SIZE(192)) u_aes192 (
        .clk_i(clk), .rst_i(rst),
`ifdef AES_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_state_i(in_state),
        .in_key_i(key_in[191:0]), .rc_state_o(rc_st[1]), .rc_key_o(rc_key1),
        .rc_num_o(rc_num[1]), .rc_state_out_i(rc_out1), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .out_state_o(os[1]), .busy_o(busy[1]));

    aes_iter_ctrl #(.KEY_SIZE(256)) u_aes256 (
        .clk_i(clk), .rst_i(rst),
`ifdef AES_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_state_i(in_state),
        .in_key_i(key_in), .rc_state_o(rc_st[2]), .rc_key_o(rc_key2),
        .rc_num_o(rc_num[2]), .rc_state_out_i(rc_out2), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .out_state_o(os[2]), .busy_o(busy[2]));

    // ---------------- helpers ----------------
    function automatic int nr_of(input int idx);
        return 10 + 2 * idx;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int idx, output int n);
        n = 0;
        while (!out_valid[idx] && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_num(input int idx, input logic [3:0] num);
        int n;
        n = 0;
        while (rc_num[idx] != num && n < 40) begin
            tick();
            n++;
        end
        check("reach round", 128'(rc_num[idx]), 128'(num));
    endtask

    task automatic run_block(input int idx, input logic [127:0] pt, input logic [255:0] key,
                             input logic [127:0] exp, input string name);
        int n;
        n = 0;
        while (!in_ready[idx] && n < 40) begin
            tick();
            n++;
        end
        in_state = pt; key_in = key; in_valid[idx] = 1'b1;
        tick();
        in_valid[idx] = 1'b0;
        wait_valid(idx, n);
        check({name, " accept-to-valid edges"}, 128'(n), 128'(nr_of(idx)));
        check({name, " ciphertext"}, os[idx], exp);
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
        check({name, " back to idle"}, 128'(in_ready[idx]), 128'd1);
        check({name, " out_valid drop"}, 128'(out_valid[idx]), 128'd0);
    endtask

    typedef struct {
        int           idx;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t tbl [4];

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int acc_t [$];
        logic [127:0] cts [$];
        bit acc, pending, m_busy, m_done;
        int m_cnt, exp_num;
        logic [127:0] m_ct, m_key;

        tbl[0] = '{0, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tbl[1] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
                   256'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3925841d02dc09fbdc118597196a0b32};
        tbl[2] = '{1, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        tbl[3] = '{2, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h8ea2b7ca516745bfeafc49904b496089};

        rst = 1'b1; in_valid = '0; out_ready = '0; in_state = '0; key_in = '0;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset in_ready[%0d]", i), 128'(in_ready[i]), 128'd1);
            check($sformatf("reset out_valid[%0d]", i), 128'(out_valid[i]), 128'd0);
            check($sformatf("reset busy[%0d]", i), 128'(busy[i]), 128'd0);
            check($sformatf("reset rc_num[%0d]", i), 128'(rc_num[i]), 128'd0);
            check($sformatf("reset rc_state[%0d]", i), rc_st[i], 128'd0);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++)
            run_block(tbl[i].idx, tbl[i].pt, tbl[i].key, tbl[i].ct, $sformatf("vec%0d", i));

        // Back-pressure: ciphertext held, second block refused until released.
        in_state = tbl[0].pt; key_in = tbl[0].key; in_valid[0] = 1'b1;
        tick();
        in_state = tbl[1].pt; key_in = tbl[1].key;
        wait_valid(0, n);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp out_state", os[0], tbl[0].ct);
            check("bp in_ready", 128'(in_ready[0]), 128'd0);
            check("bp out_valid", 128'(out_valid[0]), 128'd1);
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        run_block(0, tbl[1].pt, tbl[1].key, tbl[1].ct, "bp second");

        // Back-to-back with in_valid and out_ready held high.
        in_state = tbl[0].pt; key_in = tbl[0].key; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        for (int t = 0; t < 60; t++) begin
            acc = in_valid[0] && in_ready[0];
            tick();
            if (acc) begin
                acc_t.push_back(t);
                if (acc_t.size() == 1) begin
                    in_state = tbl[1].pt; key_in = tbl[1].key;
                end else begin
                    in_valid[0] = 1'b0;
                end
            end
            if (out_valid[0]) cts.push_back(os[0]);
        end
        out_ready[0] = 1'b0;
        check("b2b accepts", 128'(acc_t.size()), 128'd2);
        check("b2b outputs", 128'(cts.size()), 128'd2);
        if (acc_t.size() == 2) check("b2b interval", 128'(acc_t[1] - acc_t[0]), 128'd12);
        if (cts.size() == 2) begin
            check("b2b ct0", cts[0], tbl[0].ct);
            check("b2b ct1", cts[1], tbl[1].ct);
        end

        // Reset in the middle of a run.
        in_state = tbl[1].pt; key_in = tbl[1].key; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        wait_num(0, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst in_ready", 128'(in_ready[0]), 128'd1);
        check("mid rst out_valid", 128'(out_valid[0]), 128'd0);
        check("mid rst rc_num", 128'(rc_num[0]), 128'd0);
        run_block(0, tbl[0].pt, tbl[0].key, tbl[0].ct, "after rst");

`ifdef AES_CTRL_ABORT_EN
        in_state = tbl[0].pt; key_in = tbl[0].key; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        wait_num(0, 4'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort run in_ready", 128'(in_ready[0]), 128'd1);
        check("abort run rc_num", 128'(rc_num[0]), 128'd0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid[0]) n++;
            tick();
        end
        check("abort run no output", 128'(n), 128'd0);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        wait_valid(0, n);
        abort = 1'b1; out_ready[0] = 1'b1;
        tick();
        abort = 1'b0; out_ready[0] = 1'b0;
        check("abort done in_ready", 128'(in_ready[0]), 128'd1);
        check("abort done out_valid", 128'(out_valid[0]), 128'd0);
        abort = 1'b1; in_state = tbl[1].pt; key_in = tbl[1].key; in_valid[0] = 1'b1;
        tick();
        abort = 1'b0; in_valid[0] = 1'b0;
        check("abort idle accept", 128'(busy[0]), 128'd1);
        wait_valid(0, n);
        check("abort idle ct", os[0], tbl[1].ct);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
`endif

        // Random traffic against a cycle-count model of the sequencer.
        m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_ct = '0; m_key = '0; pending = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!pending) begin
                in_valid[0] = ($urandom_range(0, 2) == 0);
                in_state = rand128();
                key_in = {128'h0, rand128()};
            end
            out_ready[0] = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 59) == 0);
`ifdef AES_CTRL_ABORT_EN
            abort = ($urandom_range(0, 29) == 0);
`endif
            acc = 1'b0;
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0;
            end
`ifdef AES_CTRL_ABORT_EN
            else if (abort && m_busy) begin
                m_busy = 1'b0; m_done = 1'b0;
            end
`endif
            else if (!m_busy) begin
                if (in_valid[0]) begin
                    acc = 1'b1; m_busy = 1'b1; m_done = 1'b0; m_cnt = 10;
                    m_ct = aes_encrypt(in_state, key_in, 128);
                    m_key = key_in[127:0];
                end
            end else if (!m_done) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end else if (out_ready[0]) begin
                m_busy = 1'b0; m_done = 1'b0;
            end
            pending = in_valid[0] && !acc;
            tick();
            exp_num = !m_busy ? 0 : (m_done ? 10 : 11 - m_cnt);
            check("rnd in_ready", 128'(in_ready[0]), 128'(!m_busy));
            check("rnd out_valid", 128'(out_valid[0]), 128'(m_done));
            check("rnd busy", 128'(busy[0]), 128'(m_busy));
            check("rnd rc_num", 128'(rc_num[0]), 128'(exp_num));
            if (m_busy) check("rnd rc_key", rc_key0, m_key);
            if (m_done) check("rnd ciphertext", os[0], m_ct);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
